// File: rtl/eb1_pkg.sv
// eb1_pkg: shared types and constants for the debug command sequencer.
package eb1_pkg;
  typedef enum logic [2:0] {
    DBG_IDLE,
    DBG_WAIT_HALT,
    DBG_ISSUE,
    DBG_WAIT_DONE,
    DBG_RESP
  } eb1_dbg_seq_state_t;
  localparam logic [1:0] DBG_TYPE_GPR = 2'h0;
  localparam logic [1:0] DBG_TYPE_CSR = 2'h1;
  localparam logic [1:0] DBG_TYPE_MEM = 2'h2;
endpackage

// File: rtl/eb1_dec_dbg_cmd_seq.sv
// eb1_dec_dbg_cmd_seq: sequences DM abstract GPR/CSR commands into a one-shot decode injection with timeout.
module eb1_dec_dbg_cmd_seq
  import eb1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_cmd_valid,
  output logic        dm_cmd_ready,
  input  logic        dm_cmd_write,
  input  logic [1:0]  dm_cmd_type,
  input  logic [31:0] dm_cmd_addr,
  input  logic [31:0] dm_cmd_wrdata,
  input  logic        dec_tlu_dbg_halted,
  input  logic        dec_tlu_pipe_empty,
  input  logic        dec_dbg_cmd_done,
  input  logic        dec_dbg_cmd_fail,
  input  logic [31:0] dec_dbg_rddata,
  output logic        dbg_cmd_valid,
  output logic        dbg_cmd_write,
  output logic [1:0]  dbg_cmd_type,
  output logic [31:0] dbg_cmd_addr,
  output logic [31:0] dbg_cmd_wrdata,
  output logic        dbg_rsp_valid,
  input  logic        dbg_rsp_ready,
  output logic        dbg_rsp_fail,
  output logic [31:0] dbg_rsp_data
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
  eb1_dbg_seq_state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic rsp_ld, rsp_fail_nxt, wait_st, tmo, hs, accept, ended;
  logic [31:0] rsp_data_nxt;
  assign wait_st       = state == DBG_WAIT_HALT || state == DBG_WAIT_DONE;
  assign tmo           = cnt == TMO;
  assign accept        = state == DBG_IDLE && dm_cmd_valid;
  assign hs            = state == DBG_RESP && dbg_rsp_ready;
  assign ended         = dec_dbg_cmd_done || dec_dbg_cmd_fail;
  assign dm_cmd_ready  = state == DBG_IDLE;
  assign dbg_cmd_valid = state == DBG_ISSUE;
  assign dbg_rsp_valid = state == DBG_RESP;
  always_comb begin
    nxt          = state;
    rsp_fail_nxt = 1'b1;
    rsp_data_nxt = '0;
    case (state)
      DBG_IDLE:      nxt = !dm_cmd_valid ? DBG_IDLE :
                           (dm_cmd_type == DBG_TYPE_GPR || dm_cmd_type == DBG_TYPE_CSR) ? DBG_WAIT_HALT : DBG_RESP;
      DBG_WAIT_HALT: nxt = (dec_tlu_dbg_halted && dec_tlu_pipe_empty) ? DBG_ISSUE : tmo ? DBG_RESP : DBG_WAIT_HALT;
      DBG_ISSUE:     nxt = DBG_WAIT_DONE;
      DBG_WAIT_DONE: begin
        nxt          = (ended || !dec_tlu_dbg_halted || tmo) ? DBG_RESP : DBG_WAIT_DONE;
        rsp_fail_nxt = ended ? dec_dbg_cmd_fail : 1'b1;
        rsp_data_nxt = (dec_dbg_cmd_done && !dec_dbg_cmd_fail && !dbg_cmd_write) ? dec_dbg_rddata : '0;
      end
      DBG_RESP:      nxt = dbg_rsp_ready ? DBG_IDLE : DBG_RESP;
      default:       nxt = DBG_IDLE;
    endcase
    rsp_ld = nxt == DBG_RESP && state != DBG_RESP;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= DBG_IDLE;
      cnt            <= '0;
      dbg_cmd_write  <= 1'b0;
      dbg_cmd_type   <= '0;
      dbg_cmd_addr   <= '0;
      dbg_cmd_wrdata <= '0;
      dbg_rsp_fail   <= 1'b0;
      dbg_rsp_data   <= '0;
    end else begin
      state <= nxt;
      // saturates at the timeout value; restarts on every state change
      cnt   <= (nxt != state) ? '0 : (wait_st && !tmo) ? cnt + 1'b1 : cnt;
      if (accept) begin
        dbg_cmd_write  <= dm_cmd_write;
        dbg_cmd_type   <= dm_cmd_type;
        dbg_cmd_addr   <= dm_cmd_addr;
        dbg_cmd_wrdata <= dm_cmd_wrdata;
      end else if (hs) begin
        dbg_cmd_write  <= 1'b0;
        dbg_cmd_type   <= '0;
        dbg_cmd_addr   <= '0;
        dbg_cmd_wrdata <= '0;
      end
      if (rsp_ld) begin
        dbg_rsp_fail <= rsp_fail_nxt;
        dbg_rsp_data <= rsp_data_nxt;
      end else if (hs) begin
        dbg_rsp_fail <= 1'b0;
        dbg_rsp_data <= '0;
      end
    end
  end
endmodule

// File: tb/tb_eb1_dec_dbg_cmd_seq.sv
// tb_eb1_dec_dbg_cmd_seq: random and directed checks against a transaction-level timeline model.
module tb_eb1_dec_dbg_cmd_seq;
  localparam int TMO = 255;
  logic clk = 0;
  logic rst = 0;
  logic dm_cmd_valid = 0, dm_cmd_write = 0;
  logic [1:0] dm_cmd_type = 0;
  logic [31:0] dm_cmd_addr = 0, dm_cmd_wrdata = 0;
  logic dec_tlu_dbg_halted = 0, dec_tlu_pipe_empty = 0, dec_dbg_cmd_done = 0, dec_dbg_cmd_fail = 0;
  logic [31:0] dec_dbg_rddata = 0;
  logic dbg_rsp_ready = 0;
  logic dm_cmd_ready, dbg_cmd_valid, dbg_cmd_write, dbg_rsp_valid, dbg_rsp_fail;
  logic [1:0] dbg_cmd_type;
  logic [31:0] dbg_cmd_addr, dbg_cmd_wrdata, dbg_rsp_data;

  eb1_dec_dbg_cmd_seq #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .dm_cmd_valid(dm_cmd_valid), .dm_cmd_ready(dm_cmd_ready), .dm_cmd_write(dm_cmd_write),
    .dm_cmd_type(dm_cmd_type), .dm_cmd_addr(dm_cmd_addr), .dm_cmd_wrdata(dm_cmd_wrdata),
    .dec_tlu_dbg_halted(dec_tlu_dbg_halted), .dec_tlu_pipe_empty(dec_tlu_pipe_empty),
    .dec_dbg_cmd_done(dec_dbg_cmd_done), .dec_dbg_cmd_fail(dec_dbg_cmd_fail), .dec_dbg_rddata(dec_dbg_rddata),
    .dbg_cmd_valid(dbg_cmd_valid), .dbg_cmd_write(dbg_cmd_write), .dbg_cmd_type(dbg_cmd_type),
    .dbg_cmd_addr(dbg_cmd_addr), .dbg_cmd_wrdata(dbg_cmd_wrdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_fail(dbg_rsp_fail), .dbg_rsp_data(dbg_rsp_data)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  // expected outputs, driven by the timeline model below
  logic e_ready, e_cv, e_rv, e_fail, e_w;
  logic [1:0] e_t;
  logic [31:0] e_data, e_a, e_d;

  function automatic void exp_idle();
    e_ready = 1; e_cv = 0; e_rv = 0; e_fail = 0; e_data = 0; e_w = 0; e_t = 0; e_a = 0; e_d = 0;
  endfunction

  function automatic void set_rsp(input logic f, input logic [31:0] d);
    e_rv = 1; e_fail = f; e_data = d;
  endfunction

  task automatic step(output bit ab);
    @(posedge clk or posedge rst);
    ab = rst;
  endtask

  // one command's life: accept, wait for halt, single issue, wait for retire, respond
  task automatic serve();
    bit ab, fin;
    int k;
    forever begin
      step(ab); if (ab) return;
      if (dm_cmd_valid) break;
    end
    e_ready = 0; e_w = dm_cmd_write; e_t = dm_cmd_type; e_a = dm_cmd_addr; e_d = dm_cmd_wrdata;
    if (dm_cmd_type > 2'd1) set_rsp(1, 0);
    else begin
      fin = 0; k = 0;
      forever begin
        step(ab); if (ab) return;
        if (dec_tlu_dbg_halted && dec_tlu_pipe_empty) break;
        if (k == TMO) begin set_rsp(1, 0); fin = 1; break; end
        k++;
      end
      if (!fin) begin
        e_cv = 1;
        step(ab); if (ab) return;
        e_cv = 0; k = 0;
        forever begin
          step(ab); if (ab) return;
          if (dec_dbg_cmd_done || dec_dbg_cmd_fail) begin
            set_rsp(dec_dbg_cmd_fail, (!e_w && !dec_dbg_cmd_fail) ? dec_dbg_rddata : 32'h0);
            break;
          end
          if (!dec_tlu_dbg_halted || k == TMO) begin set_rsp(1, 0); break; end
          k++;
        end
      end
    end
    forever begin
      step(ab); if (ab) return;
      if (dbg_rsp_ready) break;
    end
  endtask

  initial begin
    forever begin
      exp_idle();
      serve();
    end
  end

  // per-cycle comparison and event recording
  int p_cyc = -1, h_cyc = -1, pulses = 0;
  logic prev_h = 0;
  always @(negedge clk) begin
    chk("dm_cmd_ready", {31'b0, dm_cmd_ready}, {31'b0, e_ready});
    chk("dbg_cmd_valid", {31'b0, dbg_cmd_valid}, {31'b0, e_cv});
    chk("dbg_cmd_write", {31'b0, dbg_cmd_write}, {31'b0, e_w});
    chk("dbg_cmd_type", {30'b0, dbg_cmd_type}, {30'b0, e_t});
    chk("dbg_cmd_addr", dbg_cmd_addr, e_a);
    chk("dbg_cmd_wrdata", dbg_cmd_wrdata, e_d);
    chk("dbg_rsp_valid", {31'b0, dbg_rsp_valid}, {31'b0, e_rv});
    if (e_rv) begin
      chk("dbg_rsp_fail", {31'b0, dbg_rsp_fail}, {31'b0, e_fail});
      chk("dbg_rsp_data", dbg_rsp_data, e_data);
    end
    if (dbg_cmd_valid) begin p_cyc = cyc; pulses++; end
    if (dec_tlu_dbg_halted && !prev_h) h_cyc = cyc;
    prev_h = dec_tlu_dbg_halted;
  end

  // core side responder: done/fail scheduled relative to the injection pulse
  bit c_rand = 0, c_halted = 0, c_empty = 0, c_rsp_ready = 1;
  int c_dly = 0, c_fm = 1;
  logic [31:0] c_rddata = 0;
  initial begin
    int cd, fm;
    cd = 0; fm = 1;
    forever begin
      @(posedge clk); #1;
      if (c_rand) begin
        dec_tlu_dbg_halted = ($urandom % 8) != 0;
        dec_tlu_pipe_empty = ($urandom % 4) != 0;
        dec_dbg_rddata = $urandom;
        dbg_rsp_ready = ($urandom % 3) != 0;
      end else begin
        dec_tlu_dbg_halted = c_halted;
        dec_tlu_pipe_empty = c_empty;
        dec_dbg_rddata = c_rddata;
        dbg_rsp_ready = c_rsp_ready;
      end
      dec_dbg_cmd_done = 0; dec_dbg_cmd_fail = 0;
      if (dbg_cmd_valid) begin
        cd = c_rand ? int'($urandom_range(0, 5)) : c_dly;
        fm = c_rand ? (($urandom % 4 == 0) ? int'($urandom_range(2, 3)) : 1) : c_fm;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          dec_dbg_cmd_done = fm != 3;
          dec_dbg_cmd_fail = fm >= 2;
        end
      end
    end
  end

  int acc, r_cyc;

  task automatic send(input logic w, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    while (!dm_cmd_ready && n < 1000) begin @(posedge clk); #2; n++; end
    if (!dm_cmd_ready) chk("send_ready_timeout", 0, 1);
    dm_cmd_valid = 1; dm_cmd_write = w; dm_cmd_type = t; dm_cmd_addr = a; dm_cmd_wrdata = d;
    acc = cyc;
    @(posedge clk); #2;
    dm_cmd_valid = 0; dm_cmd_write = 0; dm_cmd_type = 0; dm_cmd_addr = 0; dm_cmd_wrdata = 0;
  endtask

  task automatic wait_rsp(input int budget);
    int n;
    n = 0;
    r_cyc = -1;
    while (n < budget) begin
      @(negedge clk);
      if (dbg_rsp_valid) begin r_cyc = cyc; break; end
      n++;
    end
    if (r_cyc < 0) chk("rsp_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!dm_cmd_ready && n < budget);
    if (!dm_cmd_ready) chk("idle_timeout", 0, 1);
    @(posedge clk); #2;
  endtask

  initial begin
    int pc;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("reset_ready", {31'b0, dm_cmd_ready}, 1);
    chk("reset_rsp_valid", {31'b0, dbg_rsp_valid}, 0);
    @(posedge clk); #2;
    // 1: already halted, GPR read x5
    c_halted = 1; c_empty = 1; c_dly = 2; c_fm = 1; c_rddata = 32'hDEADBEEF;
    repeat (2) @(posedge clk); #2;
    send(0, 2'd0, 32'd5, 32'h0);
    wait_rsp(50);
    chk("t1_pulse_lat", p_cyc - acc, 2);
    chk("t1_rsp_lat", r_cyc - p_cyc, 3);
    chk("t1_data", dbg_rsp_data, 32'hDEADBEEF);
    chk("t1_fail", {31'b0, dbg_rsp_fail}, 0);
    wait_idle(20);
    // 2: CSR write while running, halt arrives later
    c_halted = 0;
    repeat (3) @(posedge clk); #2;
    pc = pulses;
    send(1, 2'd1, 32'h7C4, 32'h1);
    repeat (10) @(posedge clk); #2;
    chk("t2_no_early_pulse", pulses - pc, 0);
    c_halted = 1;
    wait_rsp(50);
    chk("t2_one_pulse", pulses - pc, 1);
    chk("t2_pulse_after_halt", p_cyc - h_cyc, 1);
    chk("t2_fail", {31'b0, dbg_rsp_fail}, 0);
    chk("t2_data", dbg_rsp_data, 0);
    wait_idle(20);
    // 3: memory type rejected without injection
    pc = pulses;
    send(0, 2'd2, 32'h1000, 32'h0);
    wait_rsp(10);
    chk("t3_rsp_lat", r_cyc - acc, 1);
    chk("t3_fail", {31'b0, dbg_rsp_fail}, 1);
    chk("t3_no_pulse", pulses - pc, 0);
    wait_idle(20);
    // 4: never halted -> timeout
    c_halted = 0;
    repeat (2) @(posedge clk); #2;
    send(0, 2'd0, 32'd1, 32'h0);
    wait_rsp(400);
    chk("t4_timeout_lat", r_cyc - acc, 257);
    chk("t4_fail", {31'b0, dbg_rsp_fail}, 1);
    wait_idle(20);
    // 5: done and fail together, response held back 20 cycles
    c_halted = 1; c_dly = 3; c_fm = 2; c_rsp_ready = 0;
    repeat (2) @(posedge clk); #2;
    send(0, 2'd1, 32'h300, 32'h0);
    wait_rsp(50);
    chk("t5_fail", {31'b0, dbg_rsp_fail}, 1);
    chk("t5_data", dbg_rsp_data, 0);
    repeat (20) @(negedge clk);
    chk("t5_held_valid", {31'b0, dbg_rsp_valid}, 1);
    chk("t5_held_ready", {31'b0, dm_cmd_ready}, 0);
    chk("t5_held_fail", {31'b0, dbg_rsp_fail}, 1);
    @(posedge clk); #2;
    c_rsp_ready = 1;
    wait_idle(20);
    // 6: reset during WAIT_DONE, then a clean command
    c_dly = 0; c_fm = 1;
    send(1, 2'd0, 32'd7, 32'hCAFE0001);
    repeat (4) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("t6_rst_ready", {31'b0, dm_cmd_ready}, 1);
    chk("t6_rst_write", {31'b0, dbg_cmd_write}, 0);
    chk("t6_rst_addr", dbg_cmd_addr, 0);
    chk("t6_rst_wrdata", dbg_cmd_wrdata, 0);
    chk("t6_rst_rsp_valid", {31'b0, dbg_rsp_valid}, 0);
    @(posedge clk); #2 rst = 0;
    c_dly = 1; c_rddata = 32'h12345678;
    @(posedge clk); #2;
    send(0, 2'd0, 32'd3, 32'h0);
    wait_rsp(50);
    chk("t6_data", dbg_rsp_data, 32'h12345678);
    chk("t6_fail", {31'b0, dbg_rsp_fail}, 0);
    wait_idle(20);
    // randomized traffic
    c_rand = 1;
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom % 2), ($urandom % 5 == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)),
           $urandom, $urandom);
      wait_idle(1200);
    end
    c_rand = 0;
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
